// File: rtl/hp_compressor.sv
// Feed-forward dynamics compressor: rectify, attack/release envelope, Q1.14 gain
// from a restoring divider, then gain application with symmetric clipping.
module hp_compressor #(
  parameter int ATTACK_SHIFT  = 4,
  parameter int RELEASE_SHIFT = 10,
  parameter int GAIN_FRAC     = 14
) (
  input  logic                 clk_144,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [2:0]           threshold,
  input  logic [1:0]           ratio,
  input  logic signed [15:0]   compIn,
  output logic signed [15:0]   compOut,
  output logic                 out_valid,
  output logic [GAIN_FRAC:0]   gain,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [GAIN_FRAC:0] UNITY = (GAIN_FRAC+1)'(1 << GAIN_FRAC);
  localparam logic [3:0] DIV_LAST = 4'(GAIN_FRAC + 1);

  typedef enum logic [2:0] {IDLE, RECT, ENV, DIV, APPLY} state_t;

  state_t                state;
  logic signed [15:0]    x_reg;
  logic [15:0]           rect;
  logic [23:0]           env;
  logic [3:0]            div_cnt;
  logic [15:0]           divisor;
  logic [15:0]           rem;
  logic [GAIN_FRAC:0]    num_low;
  logic [GAIN_FRAC:0]    quot;

  logic [15:0]           abs_x;
  logic [23:0]           target, up_diff, dn_diff, up_step, dn_step, env_next;
  logic [15:0]           env_int, thr_val, lvl, div_level, div_divisor;
  logic                  unity_case;
  logic [16:0]           trial;
  logic                  take;
  logic [GAIN_FRAC:0]    quot_next;
  logic [15:0]           rem_next;
  logic signed [31:0]    prod, scaled;
  logic signed [15:0]    clipped;

  // The most negative input has no positive twin, so it saturates.
  always_comb begin
    abs_x = x_reg[15] ? 16'(-x_reg) : 16'(x_reg);
    if (x_reg == 16'sh8000) abs_x = 16'h7fff;
  end

  // Envelope step, never smaller than one LSB so the envelope lands exactly on target.
  always_comb begin
    target  = {rect, 8'h00};
    up_diff = target - env;
    dn_diff = env - target;
    up_step = up_diff >> ATTACK_SHIFT;
    dn_step = dn_diff >> RELEASE_SHIFT;
    if (up_step == 24'd0) up_step = 24'd1;
    if (dn_step == 24'd0) dn_step = 24'd1;
    if (target > env)      env_next = env + up_step;
    else if (target < env) env_next = env - dn_step;
    else                   env_next = env;
  end

  always_comb begin
    env_int = env[23:8];
    case (threshold)
      3'd1:    thr_val = 16'd16384;
      3'd2:    thr_val = 16'd8192;
      3'd3:    thr_val = 16'd4096;
      3'd4:    thr_val = 16'd2048;
      default: thr_val = 16'd0;
    endcase
    unity_case = (thr_val == 16'd0) || (env_int == 16'd0) || (env_int <= thr_val);
    lvl        = thr_val + ((env_int - thr_val) >> ratio);
    // Unity is produced as 1/1 so the divider always runs the same number of steps.
    div_level   = unity_case ? 16'd1 : lvl;
    div_divisor = unity_case ? 16'd1 : env_int;
  end

  always_comb begin
    trial     = {rem, num_low[GAIN_FRAC]};
    take      = trial >= {1'b0, divisor};
    quot_next = {quot[GAIN_FRAC-1:0], take};
    rem_next  = take ? 16'(trial - {1'b0, divisor}) : trial[15:0];
  end

  always_comb begin
    prod   = x_reg * $signed({1'b0, gain});
    scaled = prod >>> GAIN_FRAC;
    if (scaled > 32'sd32767)       clipped = 16'sd32767;
    else if (scaled < -32'sd32767) clipped = -16'sd32767;
    else                           clipped = scaled[15:0];
  end

  always_ff @(posedge clk_144) begin
    if (reset) begin
      state     <= IDLE;
      x_reg     <= '0;
      rect      <= '0;
      env       <= '0;
      div_cnt   <= '0;
      divisor   <= '0;
      rem       <= '0;
      num_low   <= '0;
      quot      <= '0;
      compOut   <= '0;
      out_valid <= 1'b0;
      gain      <= UNITY;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample_en && busy) overrun <= 1'b1;
      case (state)
        IDLE: begin
          // busy is still high during the out_valid cycle, so a strobe there is an overrun.
          if (sample_en && !busy) begin
            x_reg <= compIn;
            busy  <= 1'b1;
            state <= RECT;
          end else begin
            busy <= 1'b0;
          end
        end
        RECT: begin
          rect  <= abs_x;
          state <= ENV;
        end
        ENV: begin
          env     <= env_next;
          div_cnt <= '0;
          state   <= DIV;
        end
        DIV: begin
          div_cnt <= div_cnt + 4'd1;
          if (div_cnt == 4'd0) begin
            divisor <= div_divisor;
            rem     <= div_level >> 1;
            num_low <= {div_level[0], GAIN_FRAC'(0)};
            quot    <= '0;
          end else begin
            rem     <= rem_next;
            num_low <= num_low << 1;
            quot    <= quot_next;
            if (div_cnt == DIV_LAST) begin
              gain  <= quot_next;
              state <= APPLY;
            end
          end
        end
        APPLY: begin
          compOut   <= clipped;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
